// File: rtl/sd_stream_pkg.sv
// Shared types and defaults for the SD-card song streaming scheduler.
package sd_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_FETCH     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  localparam int DEF_BLOCK_BYTES = 512;
  localparam int DEF_FIFO_DEPTH  = 4096;
  localparam int DEF_ADDR_STEP   = 512;

endpackage

// File: rtl/song_menu_counter.sv
// Wrap-around menu selection counter driven by debounced up/down pulses.
module song_menu_counter
  import sd_stream_pkg::*;
#(
  parameter  int NUM_SONGS = 4,
  localparam int SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic              up_in,
  input  logic              down_in,
  output logic [SONG_W-1:0] song_num
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic [SONG_W-1:0] song_num_r;

  // Selection register: up has priority over down, both wrap at the table ends.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      song_num_r <= {SONG_W{1'b0}};
    end else if (en && up_in) begin
      song_num_r <= (song_num_r == {SONG_W{1'b0}}) ? LAST_SONG : song_num_r - SONG_W'(1);
    end else if (en && down_in) begin
      song_num_r <= (song_num_r == LAST_SONG) ? {SONG_W{1'b0}} : song_num_r + SONG_W'(1);
    end else begin
      song_num_r <= song_num_r;
    end
  end

  assign song_num = song_num_r;

endmodule

// File: rtl/sd_stream_scheduler.sv
// Picks a song from the address table and streams its SD blocks into the audio FIFO,
// one outstanding block read at a time, with pause, stop, loop and read-timeout handling.
module sd_stream_scheduler
  import sd_stream_pkg::*;
#(
  parameter  int NUM_SONGS      = 4,
  parameter  int ADDR_W         = 32,
  parameter  int BLOCK_BYTES    = DEF_BLOCK_BYTES,
  parameter  int ADDR_STEP      = DEF_ADDR_STEP,
  parameter  int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter  int TIMEOUT_CYCLES = 2000000,
  localparam int SONG_W         = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_SONGS*ADDR_W-1:0]   song_start_flat,
  input  logic [NUM_SONGS*ADDR_W-1:0]   song_end_flat,
  input  logic                          up_in,
  input  logic                          down_in,
  input  logic                          select_in,
  input  logic                          stop_in,
  input  logic                          pause_in,
  input  logic                          loop_in,
  input  logic [LVL_W-1:0]              fifo_level,
  input  logic                          sd_done,
  output logic                          read_block,
  output logic [ADDR_W-1:0]             address,
  output logic [SONG_W-1:0]             song_num,
  output logic                          stream_en,
  output logic                          song_done,
  output logic                          sd_error,
  output logic [2:0]                    state_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W:0]    ROOM_MAX = (LVL_W + 1)'(FIFO_DEPTH - BLOCK_BYTES);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cur_addr_r, cur_addr_s, end_addr_r, end_addr_s;
  logic [ADDR_W-1:0] start_addr_r, start_addr_s, address_r, address_s;
  logic [TMR_W-1:0]  timer_r, timer_s;
  logic              read_block_r, read_block_s, stream_en_r, stream_en_s;
  logic              song_done_r, song_done_s, sd_error_r, sd_error_s;
  logic              stop_pend_r, stop_pend_s, stop_seen_s;
  logic              room_s, menu_en_s;
  logic [ADDR_W-1:0] tbl_start_s, tbl_end_s;

  assign tbl_start_s = song_start_flat[int'(song_num) * ADDR_W +: ADDR_W];
  assign tbl_end_s   = song_end_flat[int'(song_num) * ADDR_W +: ADDR_W];
  assign room_s      = ({1'b0, fifo_level} <= ROOM_MAX);
  assign menu_en_s   = (state_r == ST_IDLE) && !select_in;
  assign stop_seen_s = stop_pend_r | stop_in;

  song_menu_counter #(.NUM_SONGS(NUM_SONGS)) u_menu (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en      (menu_en_s),
    .up_in   (up_in),
    .down_in (down_in),
    .song_num(song_num)
  );

  // Next-state and next-output decode; a stop during a read is deferred until it resolves.
  always_comb begin
    state_s      = state_r;
    cur_addr_s   = cur_addr_r;
    end_addr_s   = end_addr_r;
    start_addr_s = start_addr_r;
    address_s    = address_r;
    timer_s      = timer_r;
    read_block_s = 1'b0;
    song_done_s  = 1'b0;
    stream_en_s  = stream_en_r;
    sd_error_s   = sd_error_r;
    stop_pend_s  = stop_pend_r;
    case (state_r)
      ST_IDLE: begin
        stop_pend_s = 1'b0;
        timer_s     = {TMR_W{1'b0}};
        if (select_in) begin
          start_addr_s = tbl_start_s;
          cur_addr_s   = tbl_start_s;
          end_addr_s   = tbl_end_s;
          sd_error_s   = 1'b0;
          state_s      = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (stop_in) begin
          stream_en_s = 1'b0;
          state_s     = ST_IDLE;
        end else if (cur_addr_r >= end_addr_r) begin
          state_s = ST_DRAIN;
        end else if (!pause_in && room_s) begin
          read_block_s = 1'b1;
          address_s    = cur_addr_r;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_FETCH: begin
        timer_s     = {TMR_W{1'b0}};
        stop_pend_s = stop_seen_s;
        state_s     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (sd_done) begin
          cur_addr_s = cur_addr_r + STEP;
          timer_s    = {TMR_W{1'b0}};
          if (stop_seen_s) begin
            stream_en_s = 1'b0;
            state_s     = ST_IDLE;
          end else begin
            stream_en_s = 1'b1;
            state_s     = ST_CHECK;
          end
        end else if (timer_r == TMR_LAST) begin
          timer_s     = {TMR_W{1'b0}};
          sd_error_s  = 1'b1;
          stream_en_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          timer_s     = timer_r + TMR_W'(1);
          stop_pend_s = stop_seen_s;
          state_s     = ST_WAIT_DONE;
        end
      end
      ST_DRAIN: begin
        if (stop_in) begin
          stream_en_s = 1'b0;
          state_s     = ST_IDLE;
        end else if (fifo_level == {LVL_W{1'b0}}) begin
          if (loop_in) begin
            cur_addr_s = start_addr_r;
            state_s    = ST_CHECK;
          end else begin
            song_done_s = 1'b1;
            stream_en_s = 1'b0;
            state_s     = ST_IDLE;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        stream_en_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= {ADDR_W{1'b0}};
      end_addr_r   <= {ADDR_W{1'b0}};
      start_addr_r <= {ADDR_W{1'b0}};
      address_r    <= {ADDR_W{1'b0}};
      timer_r      <= {TMR_W{1'b0}};
      read_block_r <= 1'b0;
      song_done_r  <= 1'b0;
      stream_en_r  <= 1'b0;
      sd_error_r   <= 1'b0;
      stop_pend_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cur_addr_r   <= cur_addr_s;
      end_addr_r   <= end_addr_s;
      start_addr_r <= start_addr_s;
      address_r    <= address_s;
      timer_r      <= timer_s;
      read_block_r <= read_block_s;
      song_done_r  <= song_done_s;
      stream_en_r  <= stream_en_s;
      sd_error_r   <= sd_error_s;
      stop_pend_r  <= stop_pend_s;
    end
  end

  assign read_block = read_block_r;
  assign address    = address_r;
  assign stream_en  = stream_en_r;
  assign song_done  = song_done_r;
  assign sd_error   = sd_error_r;
  assign state_out  = state_r;

endmodule

// File: tb/tb_sd_stream_scheduler.sv
// Directed + randomized bench for sd_stream_scheduler against a song-table/address-list model.
module tb_sd_stream_scheduler;

  localparam int NS = 4, AW = 32, STEP = 512, TMO = 100, LVL_W = 13, SONG_W = 2;
  localparam int S_IDLE = 0, S_CHECK = 1, S_WAIT = 3, S_DRAIN = 4;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [NS*AW-1:0]  song_start_flat, song_end_flat;
  logic              up_in, down_in, select_in, stop_in, pause_in, loop_in, sd_done;
  logic [LVL_W-1:0]  fifo_level;
  logic              read_block, stream_en, song_done, sd_error;
  logic [AW-1:0]     address;
  logic [SONG_W-1:0] song_num;
  logic [2:0]        state_out;

  int total = 0, bad = 0, model_num = 0, sd_pulses = 0;
  logic [31:0] start_m [NS];
  logic [31:0] end_m   [NS];

  sd_stream_scheduler #(.NUM_SONGS(NS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .song_start_flat(song_start_flat), .song_end_flat(song_end_flat),
    .up_in(up_in), .down_in(down_in), .select_in(select_in), .stop_in(stop_in),
    .pause_in(pause_in), .loop_in(loop_in), .fifo_level(fifo_level), .sd_done(sd_done),
    .read_block(read_block), .address(address), .song_num(song_num),
    .stream_en(stream_en), .song_done(song_done), .sd_error(sd_error),
    .state_out(state_out)
  );

  always #20 clk_in = ~clk_in;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (song_done) sd_pulses++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < NS; i++) begin
      song_start_flat[i*AW +: AW] = start_m[i];
      song_end_flat[i*AW +: AW]   = end_m[i];
    end
  endtask

  task automatic goto_song(input int idx);
    for (int k = 0; k < NS && model_num != idx; k++) begin
      down_in = 1'b1; tick(); down_in = 1'b0;
      model_num = (model_num + 1) % NS;
      chk("menu_nav", song_num, model_num);
    end
  endtask

  task automatic select_song();
    select_in = 1'b1; tick(); select_in = 1'b0;
  endtask

  task automatic expect_read(input string tag, input logic [31:0] exp_addr);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 40) begin
      if (read_block) seen = 1'b1;
      else begin tick(); n++; end
    end
    chk({tag, "_req"}, seen, 1);
    chk({tag, "_addr"}, address, exp_addr);
  endtask

  // Emulates the SD engine answering the request currently on the bus after lat cycles.
  task automatic pulse_done(input int lat, input logic [31:0] exp_addr);
    tick();
    chk("rd_one_cycle", read_block, 0);
    repeat (lat - 1) tick();
    chk("addr_stable", address, exp_addr);
    sd_done = 1'b1; tick(); sd_done = 1'b0;
  endtask

  task automatic expect_end(input string tag);
    int reads = 0;
    fifo_level = LVL_W'($urandom_range(1, 3584));
    sd_pulses = 0;
    repeat (3) begin tick(); if (read_block) reads++; end
    chk({tag, "_no_extra_rd"}, reads, 0);
    chk({tag, "_drain"}, state_out, S_DRAIN);
    chk({tag, "_no_early_done"}, sd_pulses, 0);
    fifo_level = '0;
    tick();
    chk({tag, "_song_done"}, song_done, 1);
    chk({tag, "_idle"}, state_out, S_IDLE);
    chk({tag, "_stream_off"}, stream_en, 0);
    tick();
    chk({tag, "_done_pulse"}, song_done, 0);
  endtask

  initial begin
    int reads, n, r, idx, nblk, lat;
    logic [31:0] a;
    logic [31:0] q[$];

    rst_in = 1'b1; up_in = 1'b0; down_in = 1'b0; select_in = 1'b0; stop_in = 1'b0;
    pause_in = 1'b0; loop_in = 1'b0; sd_done = 1'b0; fifo_level = '0;
    start_m = '{32'd0, 32'd4096, 32'd0, 32'd8192};
    end_m   = '{32'd2048, 32'd5120, 32'd512, 32'd9728};
    load_table();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    chk("rst_read_block", read_block, 0);
    chk("rst_address", address, 0);
    chk("rst_song_num", song_num, 0);
    chk("rst_stream_en", stream_en, 0);
    chk("rst_song_done", song_done, 0);
    chk("rst_sd_error", sd_error, 0);
    chk("rst_state", state_out, S_IDLE);

    // Four-block song streamed in order.
    fifo_level = 13'd1000;
    select_song();
    for (int k = 0; k < 4; k++) begin
      expect_read("t1", 32'(k * STEP));
      pulse_done(10, 32'(k * STEP));
      if (k == 0) chk("t1_stream_on", stream_en, 1);
    end
    expect_end("t1");

    // FIFO-room threshold.
    goto_song(1);
    fifo_level = 13'd3585;
    select_song();
    reads = 0;
    repeat (5) begin tick(); if (read_block) reads++; end
    chk("t2_no_room", reads, 0);
    chk("t2_check", state_out, S_CHECK);
    fifo_level = 13'd3584;
    tick();
    chk("t2_room_rd", read_block, 1);
    chk("t2_room_addr", address, 4096);
    pulse_done(10, 32'd4096);
    expect_read("t2b", 32'd4608);
    pulse_done(7, 32'd4608);
    expect_end("t2");

    // Menu wrap and priority.
    goto_song(0);
    up_in = 1'b1; tick(); up_in = 1'b0; model_num = NS - 1;
    chk("t3_up_wrap", song_num, 3);
    repeat (2) begin down_in = 1'b1; tick(); down_in = 1'b0; end
    model_num = 1;
    chk("t3_down2", song_num, 1);
    up_in = 1'b1; down_in = 1'b1; tick(); up_in = 1'b0; down_in = 1'b0;
    model_num = 0;
    chk("t3_up_prio", song_num, 0);
    repeat (8) begin
      r = $urandom_range(0, 2);
      up_in = (r != 1); down_in = (r != 0);
      tick(); up_in = 1'b0; down_in = 1'b0;
      model_num = (r == 1) ? (model_num + 1) % NS : (model_num + NS - 1) % NS;
      chk("t3_rand_menu", song_num, model_num);
    end

    // Pause during an in-flight read.
    goto_song(3);
    fifo_level = '0;
    select_song();
    expect_read("t4", 32'd8192);
    tick();
    pause_in = 1'b1;
    chk("t4_wait", state_out, S_WAIT);
    repeat (4) tick();
    sd_done = 1'b1; tick(); sd_done = 1'b0;
    chk("t4_done_accepted", state_out, S_CHECK);
    chk("t4_stream_on", stream_en, 1);
    reads = 0;
    repeat (6) begin tick(); if (read_block) reads++; end
    chk("t4_paused_no_rd", reads, 0);
    pause_in = 1'b0;
    expect_read("t4b", 32'd8704);
    pulse_done(3, 32'd8704);
    expect_read("t4c", 32'd9216);
    pulse_done(3, 32'd9216);
    expect_end("t4");

    // Stop during a read, then stop while waiting for room.
    sd_pulses = 0;
    select_song();
    expect_read("t7", 32'd8192);
    tick();
    stop_in = 1'b1; up_in = 1'b1; tick(); stop_in = 1'b0; up_in = 1'b0;
    chk("t7_waits_read", state_out, S_WAIT);
    chk("t7_menu_frozen", song_num, 3);
    repeat (3) tick();
    sd_done = 1'b1; tick(); sd_done = 1'b0;
    chk("t7_idle", state_out, S_IDLE);
    chk("t7_stream_off", stream_en, 0);
    reads = 0;
    repeat (4) begin tick(); if (read_block) reads++; end
    chk("t7_no_rd", reads, 0);
    chk("t7_no_song_done", sd_pulses, 0);
    fifo_level = 13'd4000;
    select_song();
    tick();
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    chk("t7_stop_check", state_out, S_IDLE);

    // Loop on a one-block song.
    goto_song(2);
    loop_in = 1'b1; fifo_level = '0; sd_pulses = 0;
    select_song();
    expect_read("t6", 32'd0);
    pulse_done(4, 32'd0);
    expect_read("t6b", 32'd0);
    chk("t6_no_song_done", sd_pulses, 0);
    chk("t6_stream_held", stream_en, 1);
    loop_in = 1'b0;
    pulse_done(4, 32'd0);
    expect_end("t6");

    // Read timeout.
    goto_song(1);
    select_song();
    expect_read("t5", 32'd4096);
    n = 0;
    while (!sd_error && n < 300) begin tick(); n++; end
    chk("t5_tmo_window", (n >= TMO && n <= TMO + 2), 1);
    chk("t5_idle", state_out, S_IDLE);
    chk("t5_stream_off", stream_en, 0);
    sd_done = 1'b1; tick(); sd_done = 1'b0;
    chk("t5_late_done_ignored", state_out, S_IDLE);
    chk("t5_sticky", sd_error, 1);
    select_song();
    chk("t5_err_cleared", sd_error, 0);
    expect_read("t5b", 32'd4096);
    pulse_done(5, 32'd4096);
    expect_read("t5c", 32'd4608);
    pulse_done(5, 32'd4608);
    expect_end("t5");

    // Asynchronous reset mid-read.
    goto_song(3);
    select_song();
    expect_read("t8", 32'd8192);
    tick();
    rst_in = 1'b1;
    #1;
    chk("t8_state", state_out, S_IDLE);
    chk("t8_addr", address, 0);
    chk("t8_song", song_num, 0);
    #5 rst_in = 1'b0;
    model_num = 0;
    sd_done = 1'b1; tick(); sd_done = 1'b0;
    chk("t8_late_done", state_out, S_IDLE);
    chk("t8_stream", stream_en, 0);

    // Randomized songs; table scrambled after select to show it is latched.
    for (int it = 0; it < 6; it++) begin
      idx  = $urandom_range(0, NS - 1);
      nblk = $urandom_range(0, 4);
      start_m[idx] = 32'($urandom_range(0, 64) * STEP);
      end_m[idx]   = start_m[idx] + 32'(nblk * STEP) - ((nblk > 0) ? 32'($urandom_range(0, 511)) : 32'd0);
      load_table();
      goto_song(idx);
      q.delete();
      a = start_m[idx];
      while (a < end_m[idx]) begin q.push_back(a); a = a + 32'(STEP); end
      fifo_level = LVL_W'($urandom_range(0, 3584));
      lat = $urandom_range(1, 20);
      select_song();
      song_start_flat = {$urandom, $urandom, $urandom, $urandom};
      song_end_flat   = {$urandom, $urandom, $urandom, $urandom};
      foreach (q[j]) begin
        expect_read("rnd", q[j]);
        pulse_done(lat, q[j]);
      end
      expect_end("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
